// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw, beq, addi and j, and drives the datapath selects and enables.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Fetch-stage enables depend on mem_ready, so they are also masked by reset
    // to keep the PC and IR frozen while reset is held.
    always_comb begin
        state_d    = FETCH;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUop      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready & ~reset;
                pc_write = mem_ready & ~reset;
                state_d  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign PCEn = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: directed per-cycle vectors push
// hand-computed state/output expectations that a monitor pops and compares.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       IorD, ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, IRWrite;
    logic [1:0] ALUSrcB, ALUop, PCSrc;
    logic       PCEn, illegal_op;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ALUSrcB    (ALUSrcB),
        .ALUop      (ALUop),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .illegal_op (illegal_op),
        .state      (state)
    );

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BEQ = 4'd8,
                           S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;

    // Output bundle: {IorD,ALUSrcA,RegDst,MemtoReg,RegWrite,MemWrite,IRWrite}, ALUSrcB, ALUop, PCSrc, {PCEn,illegal_op}
    localparam logic [14:0] E_RESET      = {7'b0000000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_FETCH_WAIT = {7'b0000000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_FETCH_RDY  = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b10};
    localparam logic [14:0] E_DECODE     = {7'b0000000, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_DECODE_ILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 2'b01};
    localparam logic [14:0] E_MEMADR     = {7'b0100000, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MEMRD      = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MEMWB      = {7'b0001100, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MEMWR      = {7'b1000010, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_EXEC       = {7'b0100000, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [14:0] E_ALUWB      = {7'b0010100, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_BEQ_Z      = {7'b0100000, 2'b00, 2'b01, 2'b01, 2'b10};
    localparam logic [14:0] E_BEQ_NZ     = {7'b0100000, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [14:0] E_ADDIEX     = {7'b0100000, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_ADDIWB     = {7'b0000100, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_JUMP       = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b10};

    typedef struct {
        logic [3:0]  st;
        logic [14:0] outs;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event check_now;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    // One cycle of stimulus; the expectation describes the cycle just entered.
    task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic z,
                                 input logic mr, input logic [3:0] es,
                                 input logic [14:0] eo, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = mr;
        e.st   = es;
        e.outs = eo;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic applyAsyncReset();
        exp_t e;
        @(negedge clk);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        e.st   = S_FETCH;
        e.outs = E_RESET;
        e.name = "async_reset_mid_memrd";
        exp_q.push_back(e);
        ->check_now;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or check_now);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput({e.name, "_state"}, {11'd0, state}, {11'd0, e.st});
                checkOutput({e.name, "_outs"},
                            {IorD, ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, IRWrite,
                             ALUSrcB, ALUop, PCSrc, PCEn, illegal_op}, e.outs);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        reset = 1'b1; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;
        applyStimulus(1, OP_LW, 0, 1, S_FETCH, E_RESET, "reset0");
        applyStimulus(1, OP_LW, 0, 1, S_FETCH, E_RESET, "reset1");
        // lw, op garbage in MEMRD must be ignored
        applyStimulus(0, OP_LW,  0, 1, S_FETCH,  E_FETCH_RDY, "lw_fetch");
        applyStimulus(0, OP_LW,  0, 1, S_DECODE, E_DECODE,    "lw_decode");
        applyStimulus(0, OP_LW,  0, 1, S_MEMADR, E_MEMADR,    "lw_memadr");
        applyStimulus(0, OP_BAD, 0, 1, S_MEMRD,  E_MEMRD,     "lw_memrd");
        applyStimulus(0, OP_BAD, 0, 1, S_MEMWB,  E_MEMWB,     "lw_memwb");
        // sw with a fetch wait and two MEMWR wait cycles
        applyStimulus(0, OP_SW, 0, 0, S_FETCH,  E_FETCH_WAIT, "sw_fetch_wait");
        applyStimulus(0, OP_SW, 0, 1, S_FETCH,  E_FETCH_RDY,  "sw_fetch");
        applyStimulus(0, OP_SW, 0, 1, S_DECODE, E_DECODE,     "sw_decode");
        applyStimulus(0, OP_SW, 0, 0, S_MEMADR, E_MEMADR,     "sw_memadr");
        applyStimulus(0, OP_SW, 0, 0, S_MEMWR,  E_MEMWR,      "sw_memwr0");
        applyStimulus(0, OP_SW, 0, 0, S_MEMWR,  E_MEMWR,      "sw_memwr1");
        applyStimulus(0, OP_SW, 0, 1, S_MEMWR,  E_MEMWR,      "sw_memwr2");
        // R-type, op garbage in EXECUTE must be ignored
        applyStimulus(0, OP_R,   0, 1, S_FETCH,  E_FETCH_RDY, "r_fetch");
        applyStimulus(0, OP_R,   0, 1, S_DECODE, E_DECODE,    "r_decode");
        applyStimulus(0, OP_BAD, 0, 1, S_EXEC,   E_EXEC,      "r_execute");
        applyStimulus(0, OP_BAD, 0, 1, S_ALUWB,  E_ALUWB,     "r_aluwb");
        // beq taken and not taken
        applyStimulus(0, OP_BEQ, 0, 1, S_FETCH,  E_FETCH_RDY, "beqt_fetch");
        applyStimulus(0, OP_BEQ, 1, 1, S_DECODE, E_DECODE,    "beqt_decode");
        applyStimulus(0, OP_BEQ, 1, 1, S_BEQ,    E_BEQ_Z,     "beqt_beq");
        applyStimulus(0, OP_BEQ, 0, 1, S_FETCH,  E_FETCH_RDY, "beqn_fetch");
        applyStimulus(0, OP_BEQ, 0, 1, S_DECODE, E_DECODE,    "beqn_decode");
        applyStimulus(0, OP_BEQ, 0, 1, S_BEQ,    E_BEQ_NZ,    "beqn_beq");
        // addi and j
        applyStimulus(0, OP_ADDI, 0, 1, S_FETCH,  E_FETCH_RDY, "addi_fetch");
        applyStimulus(0, OP_ADDI, 0, 1, S_DECODE, E_DECODE,    "addi_decode");
        applyStimulus(0, OP_ADDI, 0, 1, S_ADDIEX, E_ADDIEX,    "addi_ex");
        applyStimulus(0, OP_ADDI, 0, 1, S_ADDIWB, E_ADDIWB,    "addi_wb");
        applyStimulus(0, OP_J,    1, 1, S_FETCH,  E_FETCH_RDY, "j_fetch");
        applyStimulus(0, OP_J,    1, 1, S_DECODE, E_DECODE,    "j_decode");
        applyStimulus(0, OP_J,    1, 1, S_JUMP,   E_JUMP,      "j_jump");
        // unsupported opcode returns to FETCH with a single illegal_op pulse
        applyStimulus(0, OP_BAD, 1, 1, S_FETCH,  E_FETCH_RDY,  "ill_fetch");
        applyStimulus(0, OP_BAD, 1, 0, S_DECODE, E_DECODE_ILL, "ill_decode");
        applyStimulus(0, OP_BAD, 1, 0, S_FETCH,  E_FETCH_WAIT, "ill_after");
        // reset between edges in the middle of an lw
        applyStimulus(0, OP_LW, 0, 1, S_FETCH,  E_FETCH_RDY, "rst_fetch");
        applyStimulus(0, OP_LW, 0, 1, S_DECODE, E_DECODE,    "rst_decode");
        applyStimulus(0, OP_LW, 0, 0, S_MEMADR, E_MEMADR,    "rst_memadr");
        applyStimulus(0, OP_LW, 0, 0, S_MEMRD,  E_MEMRD,     "rst_memrd");
        applyAsyncReset();
        applyStimulus(1, OP_LW, 0, 1, S_FETCH,  E_RESET,      "rst_held");
        applyStimulus(0, OP_LW, 0, 0, S_FETCH,  E_FETCH_WAIT, "rst_rel_wait");
        applyStimulus(0, OP_LW, 0, 1, S_FETCH,  E_FETCH_RDY,  "rst_rel_fetch");
        applyStimulus(0, OP_LW, 0, 1, S_DECODE, E_DECODE,     "rst_rel_decode");
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL have no parameters; opcode and state encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 IorD, ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, IRWrite  output  1 each  datapath mux selects and write enables.
REQ-008 ALUSrcB, ALUop, PCSrc  output  2 each  ALU B-source select, ALU_decoder op (00 add, 01 sub, 10 funct), next-PC select (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 PCEn  output  1  PC register write enable.
REQ-010 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-011 state  output  4  current state code, for debug.

Function
REQ-012 The state codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unused and SHALL go to FETCH on the next edge.
REQ-013 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-014 The state transitions SHALL be:
- FETCH->DECODE when mem_ready=1; otherwise FETCH holds.
- DECODE->MEMADR for lw/sw, EXECUTE for R-type, BEQ for beq, ADDIEX for addi, JUMP for j.
- DECODE->FETCH for any other opcode.
- MEMADR->MEMRD for lw, MEMWR for sw.
- MEMRD->MEMWB when mem_ready=1; otherwise hold.
- MEMWR->FETCH when mem_ready=1; otherwise hold.
- EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, ALUWB, ADDIWB, BEQ and JUMP each go to FETCH.
REQ-015 Outputs other than PCEn and illegal_op SHALL be Moore (state-only) functions, except that IRWrite is gated by mem_ready. Every output not listed for a state SHALL be 0.
- FETCH: ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1 held until mem_ready.
- EXECUTE: ALUSrcA=1, ALUop=10.
- ALUWB: RegDst=1, RegWrite=1.
- BEQ: ALUSrcA=1, ALUop=01, PCSrc=01, Branch=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-016 PCWrite and Branch are internal signals. PCEn SHALL be combinational: PCWrite | (Branch & zero).
REQ-017 illegal_op SHALL be 1 only in DECODE when op is unsupported.
REQ-018 op SHALL be sampled only in DECODE and MEMADR. op changes in any other state SHALL have no effect.
REQ-019 With mem_ready held at 1, instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle (mem_ready=0) adds exactly one cycle.

Reset
REQ-020 While reset=1, state SHALL be FETCH. This SHALL take effect immediately, without waiting for clk, including in the middle of an instruction.
REQ-021 While reset=1, all outputs SHALL be 0 except ALUSrcB=01. IRWrite, PCWrite and PCEn SHALL also be forced to 0 regardless of mem_ready.
REQ-022 After reset deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-023 lw, mem_ready=1: states 0,1,2,3,4,0. In state 4, RegWrite=1 and MemtoReg=1. RegWrite SHALL be 0 in every other state of the sequence.
REQ-024 sw with mem_ready=0 for 2 cycles in MEMWR: states 0,1,2,5,5,5,0. MemWrite=1 for all three MEMWR cycles. RegWrite SHALL be 0 throughout.
REQ-025 beq: with zero=1 in BEQ, PCEn=1 and PCSrc=01. With zero=0, PCEn=0. ALUop=01 in both cases. Next state is FETCH in both cases.
REQ-026 R-type: EXECUTE drives ALUop=10 and ALUSrcA=1. ALUWB drives RegDst=1 and RegWrite=1. Sequence is 0,1,6,7,0.
REQ-027 op=111111: states 0,1,0. illegal_op=1 for exactly the DECODE cycle. No RegWrite, MemWrite or PCEn pulse occurs after FETCH.
REQ-028 reset asserted mid-MEMRD, between clock edges: state reads 0 immediately and all write enables read 0. After release, the next mem_ready=1 edge moves the state to DECODE.
